// File: rtl/cache_controller.sv
// Request-side cache controller: looks up single-byte CPU loads and stores, writes back
// dirty victims, fills or allocates on a miss, and keeps saturating hit/miss counters.
module cache_controller #(
  parameter int unsigned ADDRESS_WORD_SIZE = 32,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
  input  logic [7:0]                   cpu_wdata,
  output logic                         cpu_ready,
  output logic [7:0]                   cpu_rdata,
  output logic [ADDRESS_WORD_SIZE-1:0] cache_addr,
  output logic                         try_read,
  output logic                         try_write,
  output logic                         cache_write,
  output logic [7:0]                   cache_wdata,
  input  logic [7:0]                   cache_data,
  input  logic                         hit,
  input  logic                         dirty,
  input  logic [ADDRESS_WORD_SIZE-1:0] victim_addr,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata,
  input  logic                         mem_ack,
  output logic [CNT_WIDTH-1:0]         hit_count,
  output logic [CNT_WIDTH-1:0]         miss_count
);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, UPDATE, WRITEBACK, FILL, ALLOCATE, RESPOND
  } state_t;

  state_t                         state, next_state;
  logic [ADDRESS_WORD_SIZE-1:0]   addr_l, victim_l;
  logic                           we_l;
  logic [7:0]                     wdata_l, data_l, victim_data_l;

  assign cache_addr = addr_l;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state         <= IDLE;
      addr_l        <= '0;
      we_l          <= 1'b0;
      wdata_l       <= '0;
      data_l        <= '0;
      victim_l      <= '0;
      victim_data_l <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (cpu_req) begin
          addr_l  <= cpu_addr;
          we_l    <= cpu_we;
          wdata_l <= cpu_wdata;
        end
        COMPARE: if (hit) begin
          data_l <= cache_data;
          if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
        end else begin
          victim_l      <= victim_addr;
          victim_data_l <= cache_data;
          if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
        end
        // data_l holds the load result from either the hit or the fill
        FILL: if (mem_ack) data_l <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state  = state;
    cpu_ready   = 1'b0;
    cpu_rdata   = '0;
    try_read    = 1'b0;
    try_write   = 1'b0;
    cache_write = 1'b0;
    cache_wdata = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: if (cpu_req) next_state = LOOKUP;
      LOOKUP: begin
        try_read   = !we_l;
        try_write  = we_l;
        next_state = COMPARE;
      end
      COMPARE: begin
        if (hit)        next_state = we_l ? UPDATE : RESPOND;
        else if (dirty) next_state = WRITEBACK;
        else            next_state = we_l ? ALLOCATE : FILL;
      end
      UPDATE: begin
        cache_write = 1'b1;
        cache_wdata = wdata_l;
        next_state  = RESPOND;
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = victim_l;
        mem_wdata = victim_data_l;
        if (mem_ack) next_state = we_l ? ALLOCATE : FILL;
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_l;
        if (mem_ack) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        cache_write = 1'b1;
        cache_wdata = we_l ? wdata_l : data_l;
        next_state  = RESPOND;
      end
      RESPOND: begin
        cpu_ready  = 1'b1;
        cpu_rdata  = we_l ? 8'h00 : data_l;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Directed, table-driven bench for cache_controller with a small counter width so saturation is reachable.
module tb_cache_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_b, cpu_req, cpu_we, cpu_ready, try_read, try_write, cache_write;
  logic [AW-1:0] cpu_addr, cache_addr, victim_addr, mem_addr;
  logic [7:0]    cpu_wdata, cpu_rdata, cache_wdata, cache_data, mem_wdata, mem_rdata;
  logic          hit, dirty, mem_req, mem_we, mem_ack;
  logic [CW-1:0] hit_count, miss_count;

  cache_controller #(.ADDRESS_WORD_SIZE(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_b(rst_b), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cache_addr(cache_addr),
    .try_read(try_read), .try_write(try_write), .cache_write(cache_write), .cache_wdata(cache_wdata),
    .cache_data(cache_data), .hit(hit), .dirty(dirty), .victim_addr(victim_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        hit;
    logic        dirty;
    logic [7:0]  cdata;
    logic [31:0] vaddr;
    logic [7:0]  mrdata;
    int          wait_n;
    logic        hold;
    int          lat;
    logic [7:0]  rdata;
    logic        cw;
    logic [7:0]  cwdata;
    logic        wb;
    logic        fill;
  } vec_t;

  vec_t vecs[9];
  int   n_app = 0;
  int   n_err = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_app++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input int id, input vec_t v);
    int rn = 0, wn = 0, cwn = 0, wbn = 0, filln = 0, overlap = 0, unstable = 0;
    int lat = 0, waited = 0;
    logic in_tx = 1'b0, tx_we = 1'b0;
    logic [31:0] tx_addr = '0, look_addr = '0, wb_addr = '0, fill_addr = '0;
    logic [7:0]  tx_wd = '0, cwd = '0, rd = '0, wb_data = '0;
    @(negedge clk);
    hit = v.hit; dirty = v.dirty; cache_data = v.cdata; victim_addr = v.vaddr;
    mem_rdata = v.mrdata; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_req = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!v.hold) cpu_req = 1'b0;
      if (try_read) rn++;
      if (try_write) wn++;
      if (try_read || try_write) look_addr = cache_addr;
      if (cache_write) begin cwn++; cwd = cache_wdata; end
      if (int'(try_read) + int'(try_write) + int'(cache_write) > 1) overlap++;
      if (mem_req) begin
        if (!in_tx) begin
          in_tx = 1'b1; waited = 0;
          tx_we = mem_we; tx_addr = mem_addr; tx_wd = mem_wdata;
          if (mem_we) begin wbn++; wb_addr = mem_addr; wb_data = mem_wdata; end
          else begin filln++; fill_addr = mem_addr; end
        end else if (mem_we !== tx_we || mem_addr !== tx_addr || (tx_we && mem_wdata !== tx_wd)) begin
          unstable++;
        end
        if (waited == v.wait_n) begin mem_ack = 1'b1; in_tx = 1'b0; end
        else waited++;
      end
      if (cpu_ready) begin lat = k; rd = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    if (lat == 0) $display("FAIL v%0d timeout: no cpu_ready within 60 cycles", id);
    chk($sformatf("v%0d latency", id), lat, v.lat);
    chk($sformatf("v%0d cpu_rdata", id), rd, v.rdata);
    chk($sformatf("v%0d try_read pulses", id), rn, {31'd0, !v.we});
    chk($sformatf("v%0d try_write pulses", id), wn, {31'd0, v.we});
    chk($sformatf("v%0d lookup cache_addr", id), look_addr, v.addr);
    chk($sformatf("v%0d cache_write pulses", id), cwn, {31'd0, v.cw});
    if (v.cw) chk($sformatf("v%0d cache_wdata", id), cwd, v.cwdata);
    chk($sformatf("v%0d writebacks", id), wbn, {31'd0, v.wb});
    chk($sformatf("v%0d fills", id), filln, {31'd0, v.fill});
    if (v.wb) begin
      chk($sformatf("v%0d wb mem_addr", id), wb_addr, v.vaddr);
      chk($sformatf("v%0d wb mem_wdata", id), wb_data, v.cdata);
    end
    if (v.fill) chk($sformatf("v%0d fill mem_addr", id), fill_addr, v.addr);
    chk($sformatf("v%0d strobe overlap", id), overlap, 0);
    chk($sformatf("v%0d mem hold stability", id), unstable, 0);
    @(negedge clk);
    chk($sformatf("v%0d idle strobes", id),
        {27'd0, try_read, try_write, cache_write, mem_req, cpu_ready}, 0);
    if (v.hit) exp_hits = (exp_hits == 15) ? 15 : exp_hits + 1;
    else       exp_miss = (exp_miss == 15) ? 15 : exp_miss + 1;
    chk($sformatf("v%0d hit_count", id), hit_count, exp_hits);
    chk($sformatf("v%0d miss_count", id), miss_count, exp_miss);
  endtask

  initial begin
    //          we    addr     wdata  hit   dirty cdata  vaddr      mrdata wait hold  lat rdata  cw    cwdata wb    fill
    vecs[0] = '{1'b0, 32'h10,  8'h00, 1'b1, 1'b0, 8'h5A, 32'h0,     8'h00, 0,   1'b0, 3,  8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h10,  8'h33, 1'b1, 1'b0, 8'h5A, 32'h0,     8'h00, 0,   1'b0, 4,  8'h00, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h10,  8'h00, 1'b0, 1'b1, 8'h77, 32'h80,    8'hC4, 2,   1'b0, 10, 8'hC4, 1'b1, 8'hC4, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 32'h24,  8'h9E, 1'b0, 1'b0, 8'h12, 32'h40,    8'h00, 0,   1'b0, 4,  8'h00, 1'b1, 8'h9E, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h44,  8'h00, 1'b0, 1'b0, 8'h11, 32'h0,     8'h3C, 0,   1'b0, 5,  8'h3C, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h58,  8'h61, 1'b0, 1'b1, 8'hD2, 32'h1C0,   8'h00, 1,   1'b0, 6,  8'h00, 1'b1, 8'h61, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'h7,   8'h00, 1'b1, 1'b0, 8'hA5, 32'h0,     8'h00, 0,   1'b1, 3,  8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h90,  8'h00, 1'b0, 1'b1, 8'h0F, 32'h300,   8'hE1, 3,   1'b1, 12, 8'hE1, 1'b1, 8'hE1, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'hABCD,8'h00, 1'b1, 1'b1, 8'h42, 32'h0,     8'h00, 0,   1'b0, 3,  8'h42, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_b = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cache_data = '0; hit = 1'b0; dirty = 1'b0; victim_addr = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {cpu_ready, try_read, try_write, cache_write, mem_req, cpu_rdata, mem_addr[7:0]}, 0);
    chk("reset counters", {hit_count, miss_count}, 0);
    chk("reset cache_addr", cache_addr, 0);
    rst_b = 1'b1;

    for (int i = 0; i < 9; i++) run_req(i, vecs[i]);

    // Reset while a fill is outstanding, then a late ack.
    @(negedge clk);
    hit = 1'b0; dirty = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h30; mem_rdata = 8'h99; cpu_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    chk("rst: fill reached", mem_req, 1);
    rst_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    chk("rst: mem_req cleared", mem_req, 0);
    chk("rst: outputs cleared", {cpu_ready, try_read, try_write, cache_write, mem_addr[7:0]}, 0);
    chk("rst: counters cleared", {hit_count, miss_count}, 0);
    chk("rst: cache_addr cleared", cache_addr, 0);
    exp_hits = 0; exp_miss = 0;
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray ack ignored", {cpu_ready, try_read, try_write, cache_write, mem_req}, 0);
    @(negedge clk);
    chk("stray ack still idle", {cpu_ready, try_read, try_write, cache_write, mem_req}, 0);
    run_req(100, vecs[0]);

    // Drive hit_count past its maximum; the final run_req calls check it holds at 15.
    for (int i = 0; i < 16; i++) run_req(200 + i, vecs[8]);
    chk("hit_count saturated", hit_count, 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
